// File: rtl/gpio_bus_master.sv
// Purpose: turns read/write/set/clear commands into single-cycle peripheral bus accesses.
// Latency: accept to rsp_valid is 2 cycles for READ/WRITE, 3 for SET/CLEAR, 1 for a rejected command.
// Backpressure: one command in flight; cmd_ready stays low until the response has been taken.
//
// Ports:
//   clk, arst_n                          clock and synchronous active-low reset
//   cmd_valid/cmd_ready                  command handshake; cmd_op/cmd_addr/cmd_data latched on accept
//   rsp_valid/rsp_ready                  response handshake; rsp_data/rsp_err held while rsp_valid
//   bus_addr/bus_wdata/bus_we/bus_rdata  peripheral bus, combinational read data
module gpio_bus_master #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int ADDR_MIN   = 128,
  parameter int ADDR_MAX   = 130,
  parameter int RO_ADDR    = 129
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0]      bus_wdata,
  output logic                  bus_we,
  input  logic [WIDTH-1:0]      bus_rdata
);

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  // Latched command; held unchanged from accept until the next accept.
  typedef struct packed {
    op_e                   op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } cmd_t;

  // Address bounds sized to the address bus so every compare is unsigned ADDR_WIDTH.
  localparam logic [ADDR_WIDTH-1:0] A_MIN = ADDR_WIDTH'(ADDR_MIN);
  localparam logic [ADDR_WIDTH-1:0] A_MAX = ADDR_WIDTH'(ADDR_MAX);
  localparam logic [ADDR_WIDTH-1:0] A_RO  = ADDR_WIDTH'(RO_ADDR);

  state_t           state;
  state_t           state_nxt;
  cmd_t             cmd_q;
  logic [WIDTH-1:0] tmp_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic [WIDTH-1:0] rmw_val;
  logic             in_range;
  logic             ro_write;
  logic             cmd_legal;
  logic             accept;

  // Legality is judged on the incoming command so the accept edge can branch
  // straight to RESP without spending a cycle on a rejected command.
  always_comb begin
    in_range  = (cmd_addr >= A_MIN) && (cmd_addr <= A_MAX);
    ro_write  = (cmd_addr == A_RO) && (op_e'(cmd_op) != OP_READ);
    cmd_legal = in_range && !ro_write;
  end

  assign accept = cmd_valid && cmd_ready;

  // Merge value for SET/CLEAR, built from the word captured in RMW_RD.
  assign rmw_val = (cmd_q.op == OP_SET) ? (tmp_q | cmd_q.data)
                                        : (tmp_q & ~cmd_q.data);

  // State register.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and all combinational outputs. Bus address/data are zero
  // outside the four access states. bus_we is also gated by arst_n so a
  // reset landing in a write cycle cuts the strobe immediately.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = arst_n;
        if (cmd_valid && arst_n) begin
          if (!cmd_legal) begin
            state_nxt = RESP;
          end else begin
            case (op_e'(cmd_op))
              OP_READ:  state_nxt = RD;
              OP_WRITE: state_nxt = WR;
              default:  state_nxt = RMW_RD;
            endcase
          end
        end
      end
      RD: begin
        bus_addr  = cmd_q.addr;
        state_nxt = RESP;
      end
      WR: begin
        bus_addr  = cmd_q.addr;
        bus_wdata = cmd_q.data;
        bus_we    = arst_n;
        state_nxt = RESP;
      end
      RMW_RD: begin
        bus_addr  = cmd_q.addr;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        bus_addr  = cmd_q.addr;
        bus_wdata = rmw_val;
        bus_we    = arst_n;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command latch, RMW scratch word and response registers. The response is
  // only ever written in IDLE (on accept) and in the access states, so it is
  // naturally stable for the whole of RESP.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      cmd_q      <= '0;
      tmp_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q.op   <= op_e'(cmd_op);
        cmd_q.addr <= cmd_addr;
        cmd_q.data <= cmd_data;
        // A rejected command reports zero data; a legal one overwrites this
        // in its access cycle before RESP.
        rsp_data_q <= '0;
        rsp_err_q  <= !cmd_legal;
      end
      case (state)
        RD:      rsp_data_q <= bus_rdata;
        WR:      rsp_data_q <= cmd_q.data;
        RMW_RD:  tmp_q      <= bus_rdata;
        RMW_WR:  rsp_data_q <= rmw_val;
        default: ;
      endcase
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_gpio_bus_master.sv
// Purpose: self-checking bench for gpio_bus_master with a peripheral register model.
// Latency: scoreboard checks accept-to-rsp_valid latency per command class.
// Backpressure: exercises held responses and random rsp_ready.
module tb_gpio_bus_master;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_ST = 2'b10;
  localparam logic [1:0] OP_CL = 2'b11;

  logic        clk;
  logic        arst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [31:0] bus_rdata;

  gpio_bus_master dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral register file: combinational read, write on bus_we, plus a
  // bench-side preload port for the pin register.
  logic [31:0] mem [0:255];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_dat;
  assign bus_rdata = mem[bus_addr];
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_dat;
    else if (bus_we) mem[bus_addr] <= bus_wdata;
  end

  // Reference copy of the register contents.
  logic [31:0] mdl [0:255];

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } rsp_exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  rsp_exp_t rsp_q[$];
  wr_exp_t  wr_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: bus write scoreboard, response latency/data/stability.
  logic rv_prev = 1'b0;
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    if (!arst_n) begin
      chk("we_in_rst", bus_we, 0);
      rv_prev = 1'b0;
      we_prev = 1'b0;
    end else begin
      if (bus_we) begin
        chk("we_consec", we_prev, 0);
        if (wr_q.size() == 0) begin
          chk("we_unexpected", 1, 0);
        end else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          chk("we_addr", bus_addr, w.addr);
          chk("we_data", bus_wdata, w.data);
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          rsp_exp_t e;
          e = rsp_q[0];
          if (!rv_prev) chk("rsp_lat", cyc - e.acc, e.lat);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", rsp_err, e.err);
          if (rsp_ready) void'(rsp_q.pop_front());
        end
      end
      rv_prev = rsp_valid;
      we_prev = bus_we;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_dat  = d;
    tick();
    bd_we   = 1'b0;
    mdl[a]  = d;
  endtask

  // Offers one command, pushes the expected response/bus write on accept,
  // and returns one cycle into the command (just after the accept edge).
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d,
                      output int acc);
    rsp_exp_t    e;
    wr_exp_t     w;
    bit          ok;
    bit          legal;
    logic [31:0] nv;
    ok        = 1'b0;
    acc       = -1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok    = 1'b1;
        acc   = cyc;
        legal = (a >= 8'd128) && (a <= 8'd130) && !((op != OP_RD) && (a == 8'd129));
        e.acc = cyc;
        if (!legal) begin
          e.data = 32'h0; e.err = 1'b1; e.lat = 1;
        end else begin
          e.err = 1'b0;
          case (op)
            OP_RD: begin e.data = mdl[a]; e.lat = 2; end
            OP_WR: begin
              e.data = d; e.lat = 2; mdl[a] = d;
              w.addr = a; w.data = d; wr_q.push_back(w);
            end
            default: begin
              nv = (op == OP_ST) ? (mdl[a] | d) : (mdl[a] & ~d);
              e.data = nv; e.lat = 3; mdl[a] = nv;
              w.addr = a; w.data = nv; wr_q.push_back(w);
            end
          endcase
        end
        rsp_q.push_back(e);
      end
      tick();
    end
    cmd_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // Waits for the response handshake; optionally randomises rsp_ready.
  task automatic wait_rsp(input bit rnd);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) done = 1'b1;
      tick();
      if (rnd && !done) rsp_ready = 1'($urandom_range(0, 1));
    end
    rsp_ready = 1'b1;
    if (!done) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          a0;
    int          a1;
    logic [31:0] saved;
    arst_n    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 8'h0;
    cmd_data  = 32'h0;
    rsp_ready = 1'b1;
    bd_we     = 1'b0;
    bd_addr   = 8'h0;
    bd_dat    = 32'h0;

    // Reset state, while loading the peripheral registers.
    preload(8'd128, 32'h0);
    preload(8'd129, 32'hA5A5_1234);
    preload(8'd130, 32'h0000_000A);
    @(negedge clk);
    chk("rst_crdy",  cmd_ready, 0);
    chk("rst_rvld",  rsp_valid, 0);
    chk("rst_rdata", rsp_data, 0);
    chk("rst_rerr",  rsp_err, 0);
    chk("rst_baddr", bus_addr, 0);
    chk("rst_bwdat", bus_wdata, 0);
    tick();
    arst_n = 1'b1;
    @(negedge clk);
    chk("idle_crdy", cmd_ready, 1);
    tick();

    // WRITE then READ at 128.
    send(OP_WR, 8'd128, 32'hF, a0);
    wait_rsp(0);
    send(OP_RD, 8'd128, 32'h0, a0);
    wait_rsp(0);

    // SET then CLEAR at 130 (0x0A -> 0x0F -> 0x0C).
    send(OP_ST, 8'd130, 32'h5, a0);
    @(negedge clk);
    chk("rmw_rd_we",   bus_we, 0);
    chk("rmw_rd_addr", bus_addr, 130);
    wait_rsp(0);
    send(OP_CL, 8'd130, 32'h3, a0);
    wait_rsp(0);

    // Illegal commands: write to the pin register, read out of range.
    send(OP_WR, 8'd129, 32'hFFFF_FFFF, a0);
    wait_rsp(0);
    send(OP_RD, 8'd131, 32'h0, a0);
    wait_rsp(0);
    send(OP_ST, 8'd127, 32'h1, a0);
    wait_rsp(0);

    // Held response: READ of the pin register with rsp_ready low.
    rsp_ready = 1'b0;
    send(OP_RD, 8'd129, 32'h0, a0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_vld",  rsp_valid, 1);
      chk("hold_crdy", cmd_ready, 0);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("post_hold_crdy", cmd_ready, 1);
    chk("post_hold_rvld", rsp_valid, 0);
    tick();

    // Throughput: back-to-back READs accepted every 3 cycles.
    send(OP_RD, 8'd128, 32'h0, a0);
    send(OP_RD, 8'd130, 32'h0, a1);
    chk("thru_gap", a1 - a0, 3);
    wait_rsp(0);

    // Random mix with random response backpressure.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  op;
      logic [7:0]  a;
      logic [31:0] d;
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom_range(126, 132));
      d  = $urandom;
      send(op, a, d, a0);
      wait_rsp(1);
    end

    // Reset during the RMW_RD cycle of a SET aborts without a write.
    preload(8'd130, 32'h0000_000C);
    saved = mdl[130];
    send(OP_ST, 8'd130, 32'h10, a0);
    arst_n = 1'b0;
    #1;
    chk("abort_crdy_rst", cmd_ready, 0);
    @(posedge clk);
    #1;
    rsp_q.delete();
    wr_q.delete();
    mdl[130] = saved;
    chk("abort_we",    bus_we, 0);
    chk("abort_baddr", bus_addr, 0);
    chk("abort_bwdat", bus_wdata, 0);
    chk("abort_rvld",  rsp_valid, 0);
    chk("abort_rerr",  rsp_err, 0);
    chk("abort_rdata", rsp_data, 0);
    chk("abort_crdy",  cmd_ready, 0);
    tick();
    arst_n = 1'b1;
    @(negedge clk);
    chk("rearm_crdy", cmd_ready, 1);
    tick();
    repeat (3) tick();
    send(OP_RD, 8'd130, 32'h0, a0);
    wait_rsp(0);

    repeat (3) tick();
    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("wr_q_empty",  wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_bus_master.md
GPIO_BUS_MASTER -- requirements
Module: gpio_bus_master

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-low reset, arst_n, sampled only on the rising edge of clk.
REQ-002 Parameters SHALL be:
- WIDTH, default 32, data width.
- ADDR_WIDTH, default 8, address width.
- ADDR_MIN, default 128, lowest legal address.
- ADDR_MAX, default 130, highest legal address.
- RO_ADDR, default 129, read-only (pin) address.
REQ-003 The ports SHALL be:
- clk  in  1  clock
- arst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  00 READ, 01 WRITE, 10 SET (read-modify-write OR), 11 CLEAR (read-modify-write AND-NOT)
- cmd_addr  in  ADDR_WIDTH  register address
- cmd_data  in  WIDTH  write data or bit mask
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_data  out  WIDTH  read value, or value written
- rsp_err  out  1  command rejected, no bus write performed
- bus_addr  out  ADDR_WIDTH  peripheral address
- bus_wdata  out  WIDTH  peripheral write data
- bus_we  out  1  peripheral write strobe
- bus_rdata  in  WIDTH  peripheral combinational read data

Function
REQ-004 The FSM SHALL have the states IDLE, RD, WR, RMW_RD, RMW_WR and RESP.
REQ-005 cmd_ready SHALL be 1 only in IDLE with arst_n high; a command is accepted on an edge where cmd_valid and cmd_ready are both 1, and op, addr and data are latched then.
REQ-006 Command validation SHALL take place on acceptance:
- An address outside [ADDR_MIN, ADDR_MAX] SHALL be illegal.
- WRITE, SET or CLEAR to RO_ADDR SHALL be illegal.
- An illegal command SHALL go straight to RESP with rsp_err=1 and rsp_data=0, and SHALL cause no bus cycle.
REQ-007 A legal command SHALL transition from IDLE as follows: READ to RD, WRITE to WR, SET or CLEAR to RMW_RD.
REQ-008 RD SHALL last one cycle with bus_addr=addr and bus_we=0; bus_rdata SHALL be captured into rsp_data at the end of that cycle; the next state is RESP.
REQ-009 WR SHALL last one cycle with bus_addr=addr, bus_wdata=data and bus_we=1; rsp_data SHALL be set to data; the next state is RESP.
REQ-010 RMW_RD SHALL last one cycle with bus_we=0; bus_rdata SHALL be captured into an internal register tmp; the next state is RMW_WR.
REQ-011 RMW_WR SHALL last one cycle with bus_we=1:
- bus_wdata SHALL be tmp|data for SET and tmp&~data for CLEAR.
- rsp_data SHALL be set to that same value.
- The next state is RESP.
REQ-012 In RESP, rsp_valid SHALL be 1 and rsp_data and rsp_err SHALL be held stable; on rsp_valid&&rsp_ready the FSM SHALL return to IDLE with rsp_valid=0 in the next cycle.
REQ-013 bus_we SHALL be 1 only in WR and RMW_WR, for exactly one cycle per command, never in two consecutive cycles, and never for an illegal command.
REQ-014 Outside RD, WR, RMW_RD and RMW_WR, bus_addr and bus_wdata SHALL be driven to 0.
REQ-015 Latency from the accept edge to the first cycle of rsp_valid SHALL be 2 cycles for READ and WRITE, 3 cycles for SET and CLEAR, and 1 cycle for an illegal command.
REQ-016 With rsp_ready tied to 1, the throughput SHALL be one READ or WRITE per 3 cycles; no new command is accepted until the FSM is back in IDLE.
REQ-017 The ALU and latch widths SHALL be exactly WIDTH with no truncation; the address compare SHALL be unsigned on ADDR_WIDTH bits.

Reset
REQ-018 While arst_n=0 at a clk edge, the state SHALL become IDLE, and cmd_ready, rsp_valid, rsp_err, rsp_data, bus_addr, bus_wdata, bus_we and tmp SHALL all become 0.
REQ-019 A reset asserted in any state, including mid read-modify-write, SHALL abort the command with no response and no further bus_we; a read-modify-write aborted after RMW_RD SHALL NOT write.
REQ-020 cmd_ready SHALL be 0 in every cycle where arst_n is 0.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- WRITE addr=128 data=0xF, then READ addr=128 -> one bus_we pulse with bus_addr=128 and bus_wdata=0xF; READ rsp_data=0xF, rsp_err=0, rsp_valid 2 cycles after accept.
- Peripheral reg 130=0x0A, then SET addr=130 data=0x05 -> RMW_RD with we=0, then RMW_WR with bus_wdata=0x0F; rsp_data=0x0F; then CLEAR data=0x03 -> bus_wdata=0x0C.
- WRITE addr=129 and READ addr=131 -> rsp_err=1, rsp_data=0, bus_we never asserted, rsp_valid 1 cycle after accept.
- READ addr=129 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout; IDLE the cycle after rsp_ready=1.
- Reset asserted in the RMW_RD cycle of a SET -> no bus_we pulse afterwards, all outputs 0 after the edge, cmd_ready=1 the first cycle after arst_n returns high.
